// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
//   640x480@60 VGA raster generator (800x525 total, 25 MHz pixel clock) that
//   scans a 240x160 BGR555 frame buffer out of vram, scaled 2x into a 480x320
//   window whose top-left corner sits at (H_OFS, V_OFS).
//
//   The vram address is produced one raster position ahead, so vgac_addr
//   holds the address for the position the counters hold in the same cycle.
//   Sync, blanking and window flags travel through an RD_LAT-deep shift
//   pipeline so that everything belonging to raster position (h,v) reaches
//   the pins together, RD_LAT+1 cycles after the counters hold (h,v).
//
// Parameters
//   H_OFS   first active column of the window
//   V_OFS   first active line of the window
//   RD_LAT  vram read latency in cycles (1..3)
//
// Ports
//   clk_25mhz  pixel clock, the only clock
//   rst_n      asynchronous active-low reset
//   vgac_addr  vram halfword read address (holds outside the window)
//   vgac_data  vram read data, BGR555, valid RD_LAT cycles after vgac_addr
//   vga_r/g/b  4-bit colour, zero outside the visible area
//   vga_hs/vs  active-low syncs
//   vblank     high while the raster is outside display lines 0..479
//
// Configuration macro
//   VGA_SCANOUT_BORDER_EN  when defined, visible pixels outside the window
//                          show 4'h2 on every channel instead of black.
// -----------------------------------------------------------------------------
module vga_scanout #(
    parameter int H_OFS  = 80,
    parameter int V_OFS  = 80,
    parameter int RD_LAT = 1
) (
    input  logic        clk_25mhz,
    input  logic        rst_n,
    output logic [15:0] vgac_addr,
    input  logic [15:0] vgac_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank
);

    localparam logic [9:0]  H_LAST     = 10'd799;
    localparam logic [9:0]  V_LAST     = 10'd524;
    localparam logic [9:0]  H_VIS_LAST = 10'd639;
    localparam logic [9:0]  V_VIS_LAST = 10'd479;
    localparam logic [9:0]  H_SYNC_LO  = 10'd656;
    localparam logic [9:0]  H_SYNC_HI  = 10'd751;
    localparam logic [9:0]  V_SYNC_LO  = 10'd490;
    localparam logic [9:0]  V_SYNC_HI  = 10'd491;
    localparam logic [9:0]  WIN_H_LO   = 10'(H_OFS);
    localparam logic [9:0]  WIN_H_HI   = 10'(H_OFS + 479);
    localparam logic [9:0]  WIN_V_LO   = 10'(V_OFS);
    localparam logic [9:0]  WIN_V_HI   = 10'(V_OFS + 319);
    localparam logic [15:0] ROW_STEP   = 16'd240;

`ifdef VGA_SCANOUT_BORDER_EN
    localparam logic [3:0]  BORDER     = 4'h2;
`else
    localparam logic [3:0]  BORDER     = 4'h0;
`endif

    // Flag vector layout inside the delay pipeline
    localparam int          P_HS       = 4;
    localparam int          P_VS       = 3;
    localparam int          P_VB       = 2;
    localparam int          P_VIS      = 1;
    localparam int          P_WIN      = 0;
    // Blank/inactive pipeline content: syncs deasserted, nothing visible
    localparam logic [4:0]  PIPE_IDLE  = 5'b11000;

    logic [9:0]  hcnt_r;
    logic [9:0]  vcnt_r;
    logic [9:0]  h_nxt_s;
    logic [9:0]  v_nxt_s;
    logic        line_end_s;
    logic        h_nxt_win_s;
    logic        v_nxt_win_s;
    logic [7:0]  col_r;
    logic [7:0]  col_nxt_s;
    logic [15:0] row_base_r;
    logic [15:0] row_nxt_s;
    logic [15:0] addr_nxt_s;
    logic [4:0]  flags_s;
    logic [4:0]  pipe_r [RD_LAT];
    logic [4:0]  pipe_out_s;
    logic [3:0]  r_nxt_s;
    logic [3:0]  g_nxt_s;
    logic [3:0]  b_nxt_s;
    logic        unused_data_s;

    // Colour bits 0, 5, 10 and 15 of BGR555 are not used by the 4-bit DAC
    assign unused_data_s = ^{vgac_data[15], vgac_data[10], vgac_data[5], vgac_data[0]};

    // Next raster position: hcnt wraps at 799, vcnt steps on each h wrap
    always_comb begin
        h_nxt_s    = hcnt_r + 10'd1;
        v_nxt_s    = vcnt_r;
        line_end_s = 1'b0;
        if (hcnt_r == H_LAST) begin
            h_nxt_s    = 10'd0;
            line_end_s = 1'b1;
            if (vcnt_r == V_LAST) begin
                v_nxt_s = 10'd0;
            end else begin
                v_nxt_s = vcnt_r + 10'd1;
            end
        end else begin
            line_end_s = 1'b0;
        end
    end

    // Address for the next position: column counter steps every second
    // pixel, row base steps by 240 every second window line
    always_comb begin
        h_nxt_win_s = (h_nxt_s >= WIN_H_LO) && (h_nxt_s <= WIN_H_HI);
        v_nxt_win_s = (v_nxt_s >= WIN_V_LO) && (v_nxt_s <= WIN_V_HI);

        if (h_nxt_s == WIN_H_LO) begin
            col_nxt_s = 8'd0;
        end else if (h_nxt_win_s && (h_nxt_s[0] == WIN_H_LO[0])) begin
            col_nxt_s = col_r + 8'd1;
        end else begin
            col_nxt_s = col_r;
        end

        if (line_end_s && ((v_nxt_s == 10'd0) || (v_nxt_s == WIN_V_LO))) begin
            row_nxt_s = 16'd0;
        end else if (line_end_s && v_nxt_win_s && (v_nxt_s[0] == WIN_V_LO[0])) begin
            row_nxt_s = row_base_r + ROW_STEP;
        end else begin
            row_nxt_s = row_base_r;
        end

        if (h_nxt_win_s && v_nxt_win_s) begin
            addr_nxt_s = row_nxt_s + {8'd0, col_nxt_s};
        end else begin
            addr_nxt_s = vgac_addr;
        end
    end

    // Raster counters and address generator state
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r     <= 10'd0;
            vcnt_r     <= 10'd0;
            col_r      <= 8'd0;
            row_base_r <= 16'd0;
            vgac_addr  <= 16'd0;
        end else begin
            hcnt_r     <= h_nxt_s;
            vcnt_r     <= v_nxt_s;
            col_r      <= col_nxt_s;
            row_base_r <= row_nxt_s;
            vgac_addr  <= addr_nxt_s;
        end
    end

    // Per-position flags derived from the current counters
    always_comb begin
        flags_s        = PIPE_IDLE;
        flags_s[P_HS]  = !((hcnt_r >= H_SYNC_LO) && (hcnt_r <= H_SYNC_HI));
        flags_s[P_VS]  = !((vcnt_r >= V_SYNC_LO) && (vcnt_r <= V_SYNC_HI));
        flags_s[P_VB]  = (vcnt_r > V_VIS_LAST);
        flags_s[P_VIS] = (hcnt_r <= H_VIS_LAST) && (vcnt_r <= V_VIS_LAST);
        flags_s[P_WIN] = (hcnt_r >= WIN_H_LO) && (hcnt_r <= WIN_H_HI) &&
                         (vcnt_r >= WIN_V_LO) && (vcnt_r <= WIN_V_HI);
    end

    // Delay flags by RD_LAT so they line up with the returning vram data
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_r[i] <= PIPE_IDLE;
            end
        end else begin
            pipe_r[0] <= flags_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign pipe_out_s = pipe_r[RD_LAT-1];

    // Colour select: vram data in the window, border elsewhere, black in blanking
    always_comb begin
        r_nxt_s = 4'h0;
        g_nxt_s = 4'h0;
        b_nxt_s = 4'h0;
        if (pipe_out_s[P_VIS]) begin
            if (pipe_out_s[P_WIN]) begin
                r_nxt_s = vgac_data[4:1];
                g_nxt_s = vgac_data[9:6];
                b_nxt_s = vgac_data[14:11];
            end else begin
                r_nxt_s = BORDER;
                g_nxt_s = BORDER;
                b_nxt_s = BORDER;
            end
        end else begin
            r_nxt_s = 4'h0;
            g_nxt_s = 4'h0;
            b_nxt_s = 4'h0;
        end
    end

    // Output registers
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            vga_r  <= 4'h0;
            vga_g  <= 4'h0;
            vga_b  <= 4'h0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vblank <= 1'b0;
        end else begin
            vga_r  <= r_nxt_s;
            vga_g  <= g_nxt_s;
            vga_b  <= b_nxt_s;
            vga_hs <= pipe_out_s[P_HS];
            vga_vs <= pipe_out_s[P_VS];
            vblank <= pipe_out_s[P_VB];
        end
    end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 The block SHALL have parameter H_OFS, default 80, meaning first active column of the GBA window.
REQ-002 The block SHALL have parameter V_OFS, default 80, meaning first active line of the GBA window.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning vram read latency in cycles (1..3).
REQ-004 The block SHALL have port clk_25mhz, input, 1 bit: pixel clock, the block's only clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port vgac_addr, output, 16 bits: vram halfword read address.
REQ-007 The block SHALL have port vgac_data, input, 16 bits: vram read data, BGR555, valid RD_LAT cycles after vgac_addr.
REQ-008 The block SHALL have ports vga_r, vga_g and vga_b, outputs, 4 bits each: pixel colour.
REQ-009 The block SHALL have ports vga_hs and vga_vs, outputs, 1 bit each: syncs, active-low.
REQ-010 The block SHALL have port vblank, output, 1 bit: high while the raster is outside display lines 0..479.

Function
REQ-011 hcnt SHALL count 0..799 and wrap to 0; vcnt SHALL increment when hcnt wraps, count 0..524 and wrap to 0.
REQ-012 Display timing SHALL be: visible h 0-639, hsync h 656-751; visible v 0-479, vsync v 490-491.
REQ-013 Window: h in [H_OFS, H_OFS+479] and v in [V_OFS, V_OFS+319], i.e. 240x160 scaled 2x.
REQ-014 Inside the window, vgac_addr SHALL equal ((v-V_OFS)>>1)*240 + ((h-H_OFS)>>1), range 0..38399.
REQ-015 Address generation SHALL use no multiplier: a column counter advancing every 2 pixels, plus a row-base register adding 240 every second window line and cleared at frame wrap.
REQ-016 Outside the window, vgac_addr SHALL hold its last value.
REQ-017 Colour: r = vgac_data[4:1], g = vgac_data[9:6], b = vgac_data[14:11]; bit 15 SHALL be ignored.
REQ-018 Outside the visible area, r/g/b SHALL be 0.
REQ-019 vga_hs, vga_vs, visible, window and colour SHALL be delayed through a shift pipeline so that raster position (h,v) reaches all pins exactly RD_LAT+1 cycles after the counters hold (h,v).
REQ-020 vblank SHALL be registered and aligned with vga_vs.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 While rst_n=0: hcnt=vcnt=0, vgac_addr=0, r/g/b=0, vga_hs=1, vga_vs=1, vblank=0, pipeline cleared to the blank/inactive state.
REQ-023 Reset assertion mid-frame SHALL take effect immediately.
REQ-024 After rst_n rises, the first counter step SHALL occur on the next clk_25mhz edge, and the frame SHALL restart at (0,0).

Configuration
REQ-025 Macro VGA_SCANOUT_BORDER_EN: when defined, visible pixels outside the window SHALL output r=g=b=4'h2; when undefined, they SHALL output 0.
REQ-026 The macro SHALL NOT affect sync timing, addresses or latency.

Verification
REQ-027 Free-run 2 frames after reset: hs low for 96 of every 800 clocks; vs low for exactly 2 lines per 525; frame period 420000 clocks.
REQ-028 vram model with data=addr, RD_LAT=1: at window pixel (h=80,v=80) vgac_addr=0; at (81,81) vgac_addr=0; at (82,82) vgac_addr=241; at (559,399) vgac_addr=38399.
REQ-029 vgac_data=16'h7FFF across the window: pins show rgb=FFF at raster (80,80) exactly 2 clocks after the counters reach it; pixel (79,80) shows 0.
REQ-030 vgac_data=16'h001F: r=F, g=0, b=0; vgac_data=16'h8000: rgb=000.
REQ-031 Assert rst_n=0 at (300,200) for 3 clocks: outputs take their reset values in the same cycle; after release, vga_hs falls exactly 656+RD_LAT+1 clocks later.
REQ-032 With VGA_SCANOUT_BORDER_EN defined: pixel (10,10) shows 2/2/2 and pixel (10,490) shows 0/0/0; with the macro undefined, both show 0/0/0.
